// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: sequencer states, datapath width, helpers.
package cpu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE,
        ERR
    } state_e;

    // Two's complement negation with wrap (also used by the multiplier controller).
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: latches operands as magnitudes, runs the external
// shift-subtract core for ITER cycles, sign-fixes the result and owns HI/LO.
// A zero divisor is trapped before the core is started.
module div_ctrl #(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero_exc,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_op,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] core_lo,
    input  logic [WIDTH-1:0] core_hi
);
    import cpu_pkg::state_e, cpu_pkg::IDLE, cpu_pkg::LOAD, cpu_pkg::RUN,
           cpu_pkg::FIX, cpu_pkg::DONE, cpu_pkg::ERR, cpu_pkg::twos_neg;

    localparam int PW = cpu_pkg::WIDTH;
    localparam int CW = $clog2(ITER) + 1;

    // WIDTH-bit negation through the shared helper (WIDTH must not exceed PW).
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return WIDTH'(twos_neg(PW'(x)));
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Next-state, operand capture, iteration count, fix-up and status outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        busy         = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        div_op       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Magnitudes are captured once here and held until the next start,
                    // so the core sees stable operands for the whole run.
                    dvd_d   = (is_signed && op_a[WIDTH-1]) ? neg_w(op_a) : op_a;
                    dvs_d   = (is_signed && op_b[WIDTH-1]) ? neg_w(op_b) : op_b;
                    q_neg_d = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    r_neg_d = is_signed & op_a[WIDTH-1];
                    state_d = (op_b == '0) ? ERR : LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                cnt_d   = CW'(ITER - 1);
                state_d = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                div_op = 1'b1;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            FIX: begin
                busy    = 1'b1;
                lo_d    = q_neg_q ? neg_w(core_lo) : core_lo;
                hi_d    = r_neg_q ? neg_w(core_hi) : core_hi;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                div_zero_exc = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized scoreboard bench for div_ctrl with a behavioural divider core.
module tb_div_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, div_zero_exc, div_op;
    logic [W-1:0] hi, lo, div_dividend, div_divisor, core_lo, core_hi;

    div_ctrl #(.WIDTH(W), .ITER(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .div_zero_exc(div_zero_exc), .hi(hi), .lo(lo), .div_op(div_op),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .core_lo(core_lo), .core_hi(core_hi)
    );

    always #5 clk = ~clk;

    // Core model: result is only valid after exactly W consecutive div_op cycles;
    // a low div_op restarts its count. Anything else yields a poison value.
    logic [6:0] ccnt = '0;
    always @(posedge clk) ccnt <= div_op ? ccnt + 7'd1 : 7'd0;
    assign core_lo = (ccnt == 7'd32 && div_divisor != '0) ? div_dividend / div_divisor : 32'hDEADBEEF;
    assign core_hi = (ccnt == 7'd32 && div_divisor != '0) ? div_dividend % div_divisor : 32'hBADC0FFE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           exc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;
    exp_t sbq[$];

    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;
    int           bw_lo = 1, bw_hi = 0;   // expected busy window (cycle numbers)
    int           dw_lo = 1, dw_hi = 0;   // expected div_op window
    bit           mon_en = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Architectural reference: signed/unsigned division in 64-bit arithmetic.
    task automatic ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint na, nb;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'b0, a});
            nb = longint'({32'b0, b});
        end
        q = W'(na / nb);
        r = W'(na % nb);
    endtask

    // Monitor: timing windows, hold of HI/LO, and scoreboard pops on completion.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (!reset) begin
                mdl_hi <= '0;
                mdl_lo <= '0;
            end else begin
                chk("busy", W'(busy), W'(cyc >= bw_lo && cyc <= bw_hi));
                chk("div_op", W'(div_op), W'(cyc >= dw_lo && cyc <= dw_hi));
                if (done || div_zero_exc) begin
                    if (sbq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_completion @cyc %0d: done=%b exc=%b expected none", cyc, done, div_zero_exc);
                    end else begin
                        e = sbq.pop_front();
                        chk("exc_flag", W'(div_zero_exc), W'(e.exc));
                        chk("done_flag", W'(done), W'(!e.exc));
                        chk("finish_cycle", W'(cyc), W'(e.cyc));
                        if (e.exc) begin
                            chk("hi_kept", hi, mdl_hi);
                            chk("lo_kept", lo, mdl_lo);
                        end else begin
                            chk("hi_result", hi, e.hi);
                            chk("lo_result", lo, e.lo);
                            mdl_hi <= e.hi;
                            mdl_lo <= e.lo;
                        end
                    end
                end else begin
                    chk("hi_hold", hi, mdl_hi);
                    chk("lo_hold", lo, mdl_lo);
                end
            end
        end
    end

    // Present one start pulse; push the expected outcome when it should complete.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, output int acc);
        logic [W-1:0] q, r;
        @(posedge clk); #1;
        start = 1'b1; is_signed = s; op_a = a; op_b = b;
        acc = cyc + 1;
        if (b == '0) begin
            if (push) sbq.push_back('{1'b1, '0, '0, acc});
            bw_lo = 1; bw_hi = 0; dw_lo = 1; dw_hi = 0;
        end else begin
            ref_div(s, a, b, q, r);
            if (push) sbq.push_back('{1'b0, r, q, acc + 34});
            bw_lo = acc; bw_hi = acc + 33; dw_lo = acc + 1; dw_hi = acc + 32;
        end
        @(posedge clk); #1;
        start = 1'b0; is_signed = $urandom_range(0, 1) != 0; op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || div_zero_exc) return;
        end
        n_chk++; n_fail++;
        $display("FAIL completion_timeout @cyc %0d: got no done/exc expected one within 100 cycles", cyc);
    endtask

    task automatic op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        int acc;
        issue(s, a, b, 1'b1, acc);
        wait_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [W-1:0] ra, rb;
        bit rs;

        reset = 1'b0;
        start = 1'b1; op_a = 32'd10; op_b = 32'd2;   // reset must win over start
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_exc", W'(div_zero_exc), '0);
        chk("rst_div_op", W'(div_op), '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_dividend", div_dividend, '0);
        chk("rst_divisor", div_divisor, '0);
        reset = 1'b1;
        mon_en = 1'b1;

        op(1'b0, 32'd100, 32'd7);
        op(1'b1, 32'hFFFF_FFF9, 32'd2);
        op(1'b0, 32'hFFFF_FFF9, 32'd2);
        op(1'b0, 32'd31, 32'd7);
        op(1'b1, 32'd5, 32'd0);
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Abort in RUN cycle 10 (cycle 11 after acceptance).
        issue(1'b0, 32'd50, 32'd5, 1'b0, acc);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        bw_hi = cyc; dw_hi = cyc;
        @(posedge clk); #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_div_op", W'(div_op), '0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        reset = 1'b1;
        op(1'b0, 32'd9, 32'd3);

        // A start during RUN (with a zero divisor) must be ignored.
        issue(1'b0, 32'd1000, 32'd10, 1'b1, acc);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; is_signed = 1'b1; op_a = 32'd77; op_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end();
        op(1'b1, 32'hFFFF_FF9C, 32'd7);   // back-to-back after DONE

        for (int i = 0; i < 14; i++) begin
            rs = $urandom_range(0, 1) != 0;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = ($urandom_range(0, 1) != 0) ? -W'($urandom_range(1, 15)) : W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if (rb == '0 && $urandom_range(0, 1) != 0) rb = 32'd1;
            op(rs, ra, rb);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", W'(sbq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
